bp_predict_ctrl: RTL and testbench
==================================

Name: bp_predict_ctrl

Overview:
- Control stage directly upstream of the correlating-predictor counter RAM; sole master of the RAM's CS/WE/OE/ADDR/DATA pins.
- Keeps the m-bit global history register (GHR) and forms RAM address {GHR, PC[r-1:0]}.
- Serves prediction lookups and performs read-modify-write saturating-counter updates on branch resolution.
- After every reset, sweeps all RAM entries to weakly-not-taken before accepting requests.

Parameters:
- m, 2, global history bits (m >= 1)
- n, 2, counter width per entry (n >= 1)
- r, 8, PC index bits

Ports:
- clk  in  1  clock; all state and outputs update on posedge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high only in IDLE; requests are sampled only when ready=1
- pred_req  in  1  lookup request; upstream holds it until accepted
- pred_pc  in  r  PC index for lookup
- pred_valid  out  1  one-cycle pulse; pred_taken is valid
- pred_taken  out  1  MSB of the counter read
- res_valid  in  1  resolution request; upstream holds it until accepted
- res_pc  in  r  PC index of resolved branch
- res_taken  in  1  actual outcome
- init_done  out  1  high once the init sweep completes
- ram_cs_n  out  1  RAM chip select, active low
- ram_we_n  out  1  RAM write strobe; RAM writes on its falling edge
- ram_oe_n  out  1  RAM output enable, active low
- ram_addr  out  r+m  {GHR, pc}
- ram_wdata  out  n  write data
- ram_data_oe  out  1  top level drives the RAM DATA bus with ram_wdata when 1, else Z
- ram_rdata  in  n  RAM DATA bus as seen by the controller

Behaviour:
- All outputs registered, so RAM strobes are glitch-free (WE is edge-sensitive).
- Reset values:
  - ram_cs_n=1, ram_we_n=1, ram_oe_n=1, ram_data_oe=0, ram_addr=0, ram_wdata=0.
  - ready=0, pred_valid=0, pred_taken=0, init_done=0, GHR=0, init index=0.
  - Next state after reset is INIT_SET.
- Reset mid-operation: same values at the next edge, including mid-write. Any partial write is discarded and the init sweep restarts from index 0.
- Weak-not-taken value WNT = 2^(n-1)-1; for n=1 this is 0.
- Init sweep, 3 cycles per entry, for idx = 0 .. 2^(r+m)-1:
  - INIT_SET: addr=idx, wdata=WNT, data_oe=1, cs_n=0, we_n=1, oe_n=1.
  - INIT_STRB: we_n=0; the RAM write occurs here.
  - INIT_REL: we_n=1, cs_n=1; data_oe held at 1 for hold time; idx++.
  - After the last index: init_done=1, state IDLE.
  - Total: 3*2^(r+m) cycles.
- IDLE:
  - ready=1, all strobes inactive, data_oe=0.
  - If res_valid: accept the update (res has priority). A simultaneous pred_req is not accepted and must be held.
  - Else if pred_req: accept the lookup.
- Lookup, accepted at the edge ending cycle T:
  - Cycle T+1 (PRED_RD): addr={GHR,pred_pc}, cs_n=0, oe_n=0, we_n=1. At the edge ending T+1, capture ram_rdata and return to IDLE.
  - Cycle T+2: pred_valid=1 and pred_taken=counter[n-1] for one cycle (ready=1 again).
  - GHR is unchanged by a lookup.
- Update, accepted at T; GHR is sampled at acceptance (in-order, single-outstanding model):
  - T+1 UPD_RD: read {GHR,res_pc} as in a lookup; capture cnt.
  - T+2 UPD_SET: wdata = sat(cnt), data_oe=1, cs_n=0, oe_n=1, we_n=1.
  - T+3 UPD_STRB: we_n=0.
  - T+4 UPD_REL: we_n=1, cs_n=1, data_oe=1. At the edge ending T+4: GHR <= {GHR[m-2:0], res_taken} (for m=1: GHR <= res_taken); state IDLE.
  - Back in IDLE at T+5.
- sat(): taken with cnt == 2^n-1 stays; taken otherwise +1; not-taken with cnt == 0 stays; not-taken otherwise -1. The write is always performed, even when the value is unchanged.
- oe_n and we_n are never both low. data_oe=1 implies oe_n=1.

Decomposition:
- Package bp_pkg holds:
  - state enum: INIT_SET, INIT_STRB, INIT_REL, IDLE, PRED_RD, UPD_RD, UPD_SET, UPD_STRB, UPD_REL.
  - function sat_update(cnt, taken) parameterised on n.
  - function wnt(n).
- One natural sub-module: bp_sat_counter (combinational n-bit saturating inc/dec), reusable by future predictor variants.
- The top level instantiates bp_predict_ctrl plus RAM and owns the tristate assign.

Test Plan (r=2, m=2, n=2 unless noted):
- Reset released -> exactly 16 falling edges of ram_we_n, addr 0..15, wdata=2'b01 each; init_done and ready rise after 48 cycles; GHR=0.
- pred_req pc=2'b10 after init -> cycle T+1 addr=4'b0010, cs_n=0, oe_n=0; cycle T+2 pred_valid=1, pred_taken=0; no we_n edge.
- Taken resolves on pc=2, five in a row:
  - addresses written: 0010, 0110, 1110, 1110, 1110
  - data written: 10, 10, 10, 11, 11 (saturated)
  - GHR ends 2'b11; a following lookup pc=2 gives pred_taken=1.
- Not-taken resolves on pc=0 from GHR=11 -> addresses 1100, 1000, 0000, 0000; last write is 00 (saturated); GHR=00.
- pred_req and res_valid asserted together in IDLE (GHR=00, res pc=1 taken, pred pc=1) -> update at 0001 first (writes 10), then lookup at addr 0101 (GHR=01), pred_taken=0.
- rst asserted while in UPD_STRB -> next cycle we_n=1, cs_n=1, data_oe=0, ready=0, init_done=0; init sweep restarts at addr 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the correlating branch predictor:
// controller state encoding plus saturating-counter arithmetic.
package bp_pkg;

  typedef enum logic [3:0] {
    INIT_SET,
    INIT_STRB,
    INIT_REL,
    IDLE,
    PRED_RD,
    UPD_RD,
    UPD_SET,
    UPD_STRB,
    UPD_REL
  } bp_state_e;

  // Saturating step of a w-bit counter; only the low w bits are meaningful.
  function automatic logic [31:0] sat_update(input logic [31:0] cnt,
                                             input logic        taken,
                                             input int          w);
    logic [31:0] maxv;
    maxv = (32'd1 << w) - 32'd1;
    if (taken) begin
      sat_update = (cnt == maxv) ? cnt : cnt + 32'd1;
    end else begin
      sat_update = (cnt == 32'd0) ? cnt : cnt - 32'd1;
    end
  endfunction

  // Weakly-not-taken encoding: 2^(w-1)-1, which is 0 for a 1-bit counter.
  function automatic logic [31:0] wnt(input int w);
    wnt = (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational n-bit saturating increment/decrement for predictor counters.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int n = 2
) (
  input  logic [n-1:0] cnt,
  input  logic         taken,
  output logic [n-1:0] nxt
);

  always_comb begin
    nxt = n'(sat_update(32'(cnt), taken, n));
  end

endmodule

// File: rtl/bp_predict_ctrl.sv
// Control stage in front of the predictor counter RAM: init sweep, lookups,
// and read-modify-write counter updates with a global history register.
module bp_predict_ctrl
  import bp_pkg::*;
#(
  parameter int m = 2,
  parameter int n = 2,
  parameter int r = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic           ready,
  input  logic           pred_req,
  input  logic [r-1:0]   pred_pc,
  output logic           pred_valid,
  output logic           pred_taken,
  input  logic           res_valid,
  input  logic [r-1:0]   res_pc,
  input  logic           res_taken,
  output logic           init_done,
  output logic           ram_cs_n,
  output logic           ram_we_n,
  output logic           ram_oe_n,
  output logic [r+m-1:0] ram_addr,
  output logic [n-1:0]   ram_wdata,
  output logic           ram_data_oe,
  input  logic [n-1:0]   ram_rdata
);

  localparam int            AW       = r + m;
  localparam logic [n-1:0]  WNT      = n'(wnt(n));
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = '1;

  bp_state_e     state_q, state_d;
  logic          arm_q;
  logic [AW-1:0] idx_q, idx_d;
  logic [m-1:0]  ghr_q, ghr_d;
  logic          upd_taken_q, upd_taken_d;
  logic [AW-1:0] addr_d;
  logic [n-1:0]  wdata_d;
  logic [n-1:0]  sat_nxt;
  logic          pred_valid_d, pred_taken_d, init_done_d;
  logic          cs_n_d, we_n_d, oe_n_d, data_oe_d, ready_d;

  bp_sat_counter #(.n(n)) u_sat (
    .cnt   (ram_rdata),
    .taken (upd_taken_q),
    .nxt   (sat_nxt)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ghr_d        = ghr_q;
    upd_taken_d  = upd_taken_q;
    addr_d       = ram_addr;
    wdata_d      = ram_wdata;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken;
    init_done_d  = init_done;

    case (state_q)
      INIT_SET: begin
        // The first cycle after reset only arms the sweep so the RAM sees
        // address and data settle before the first strobe.
        if (arm_q) begin
          state_d = INIT_STRB;
        end else begin
          addr_d  = idx_q;
          wdata_d = WNT;
        end
      end
      INIT_STRB: state_d = INIT_REL;
      INIT_REL: begin
        if (idx_q == IDX_LAST) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          idx_d       = '0;
        end else begin
          state_d = INIT_SET;
          idx_d   = idx_q + IDX_ONE;
          addr_d  = idx_q + IDX_ONE;
          wdata_d = WNT;
        end
      end
      IDLE: begin
        if (res_valid) begin
          state_d     = UPD_RD;
          addr_d      = {ghr_q, res_pc};
          upd_taken_d = res_taken;
        end else if (pred_req) begin
          state_d = PRED_RD;
          addr_d  = {ghr_q, pred_pc};
        end
      end
      PRED_RD: begin
        state_d      = IDLE;
        pred_valid_d = 1'b1;
        pred_taken_d = ram_rdata[n-1];
      end
      UPD_RD: begin
        state_d = UPD_SET;
        wdata_d = sat_nxt;
      end
      UPD_SET:  state_d = UPD_STRB;
      UPD_STRB: state_d = UPD_REL;
      UPD_REL: begin
        state_d = IDLE;
        ghr_d   = m'({ghr_q, upd_taken_q});
      end
      default:  state_d = INIT_SET;
    endcase

    // Strobes are decoded from the next state and registered, so each
    // state's pin values appear during that state's cycle without glitches.
    cs_n_d    = !(state_d inside {INIT_SET, INIT_STRB, PRED_RD, UPD_RD,
                                  UPD_SET, UPD_STRB});
    we_n_d    = !(state_d inside {INIT_STRB, UPD_STRB});
    oe_n_d    = !(state_d inside {PRED_RD, UPD_RD});
    data_oe_d = state_d inside {INIT_SET, INIT_STRB, INIT_REL,
                                UPD_SET, UPD_STRB, UPD_REL};
    ready_d   = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_SET;
      arm_q       <= 1'b0;
      idx_q       <= '0;
      ghr_q       <= '0;
      ready       <= 1'b0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      init_done   <= 1'b0;
      ram_cs_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_data_oe <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= 1'b1;
      idx_q       <= idx_d;
      ghr_q       <= ghr_d;
      ready       <= ready_d;
      pred_valid  <= pred_valid_d;
      pred_taken  <= pred_taken_d;
      init_done   <= init_done_d;
      ram_cs_n    <= cs_n_d;
      ram_we_n    <= we_n_d;
      ram_oe_n    <= oe_n_d;
      ram_data_oe <= data_oe_d;
      ram_addr    <= addr_d;
      ram_wdata   <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    upd_taken_q <= upd_taken_d;
  end

endmodule

// File: tb/tb_bp_predict_ctrl.sv
// Directed bench for bp_predict_ctrl (r=2, m=2, n=2) with a behavioural
// counter RAM that writes on the falling edge of ram_we_n.
module tb_bp_predict_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready;
  logic       pred_req = 1'b0;
  logic [1:0] pred_pc = 2'd0;
  logic       pred_valid;
  logic       pred_taken;
  logic       res_valid = 1'b0;
  logic [1:0] res_pc = 2'd0;
  logic       res_taken = 1'b0;
  logic       init_done;
  logic       ram_cs_n, ram_we_n, ram_oe_n, ram_data_oe;
  logic [3:0] ram_addr;
  logic [1:0] ram_wdata;
  logic [1:0] ram_rdata;

  logic [1:0] mem [16];
  logic [3:0] wr_addr [$];
  logic [1:0] wr_data [$];
  logic       wr_oe_ok = 1'b1;
  logic       viol = 1'b0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  bp_predict_ctrl #(.m(2), .n(2), .r(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .pred_req    (pred_req),
    .pred_pc     (pred_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_taken   (res_taken),
    .init_done   (init_done),
    .ram_cs_n    (ram_cs_n),
    .ram_we_n    (ram_we_n),
    .ram_oe_n    (ram_oe_n),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_data_oe (ram_data_oe),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = (!ram_cs_n && !ram_oe_n) ? mem[ram_addr] : 2'b00;

  always @(negedge ram_we_n) begin
    if (!ram_cs_n) begin
      mem[ram_addr] = ram_wdata;
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
      if (!ram_data_oe) wr_oe_ok = 1'b0;
    end
  end

  always @(negedge clk) begin
    if ((!ram_oe_n && !ram_we_n) || (ram_data_oe && !ram_oe_n)) viol = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One resolution from IDLE through the write and back to IDLE.
  task automatic do_res(input logic [1:0] pc, input logic tk,
                        input logic [3:0] exp_addr, input logic [1:0] exp_data,
                        input string tag);
    int n0;
    n0 = wr_addr.size();
    res_valid = 1'b1;
    res_pc    = pc;
    res_taken = tk;
    step();
    res_valid = 1'b0;
    chk({tag, "_rd_addr"}, 32'(ram_addr), 32'(exp_addr));
    chk({tag, "_rd_oe"}, 32'(ram_oe_n), 32'd0);
    step();
    chk({tag, "_set_wdata"}, 32'(ram_wdata), 32'(exp_data));
    step();
    chk({tag, "_strb_we"}, 32'(ram_we_n), 32'd0);
    step();
    step();
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n0 + 1));
    chk({tag, "_wr_addr"}, 32'(wr_addr[$]), 32'(exp_addr));
    chk({tag, "_wr_data"}, 32'(wr_data[$]), 32'(exp_data));
  endtask

  task automatic do_pred(input logic [1:0] pc, input logic [3:0] exp_addr,
                         input logic exp_taken, input string tag);
    pred_req = 1'b1;
    pred_pc  = pc;
    step();
    pred_req = 1'b0;
    chk({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
    chk({tag, "_oe_cs"}, 32'({ram_cs_n, ram_oe_n, ram_we_n}), 32'b001);
    step();
    chk({tag, "_valid"}, 32'(pred_valid), 32'd1);
    chk({tag, "_taken"}, 32'(pred_taken), 32'(exp_taken));
    step();
    chk({tag, "_valid_pulse"}, 32'(pred_valid), 32'd0);
  endtask

  initial begin
    int sweep;
    int nw;
    logic ok;
    for (int i = 0; i < 16; i++) mem[i] = 2'b11;

    repeat (3) step();
    chk("rst_strobes", 32'({ram_cs_n, ram_we_n, ram_oe_n, ram_data_oe}), 32'b1110);
    chk("rst_flags", 32'({ready, pred_valid, pred_taken, init_done}), 32'b0000);
    chk("rst_addr_wdata", 32'({ram_addr, ram_wdata}), 32'd0);

    wr_addr.delete();
    wr_data.delete();
    rst = 1'b0;
    sweep = 0;
    for (int i = 0; i < 200 && !init_done; i++) begin
      step();
      if (ram_data_oe) sweep++;
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_ready", 32'(ready), 32'd1);
    chk("init_cycles", 32'(sweep), 32'd48);
    chk("init_nwrites", 32'(wr_addr.size()), 32'd16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== 2'b01) ok = 1'b0;
    end
    chk("init_addr_data", 32'(ok), 32'd1);
    chk("init_data_oe_at_write", 32'(wr_oe_ok), 32'd1);

    nw = wr_addr.size();
    do_pred(2'b10, 4'b0010, 1'b0, "pred_pc2");
    chk("pred_no_write", 32'(wr_addr.size()), 32'(nw));

    do_res(2'b10, 1'b1, 4'b0010, 2'b10, "tk1");
    do_res(2'b10, 1'b1, 4'b0110, 2'b10, "tk2");
    do_res(2'b10, 1'b1, 4'b1110, 2'b10, "tk3");
    do_res(2'b10, 1'b1, 4'b1110, 2'b11, "tk4");
    do_res(2'b10, 1'b1, 4'b1110, 2'b11, "tk5_sat");
    do_pred(2'b10, 4'b1110, 1'b1, "pred_after_tk");

    do_res(2'b00, 1'b0, 4'b1100, 2'b00, "nt1");
    do_res(2'b00, 1'b0, 4'b1000, 2'b00, "nt2");
    do_res(2'b00, 1'b0, 4'b0000, 2'b00, "nt3");
    do_res(2'b00, 1'b0, 4'b0000, 2'b00, "nt4_sat");

    // Simultaneous requests: resolution wins, lookup stays pending.
    pred_req = 1'b1;
    pred_pc  = 2'b01;
    do_res(2'b01, 1'b1, 4'b0001, 2'b10, "both_upd");
    step();
    pred_req = 1'b0;
    chk("both_pred_addr", 32'(ram_addr), 32'b0101);
    chk("both_pred_oe", 32'(ram_oe_n), 32'd0);
    step();
    chk("both_pred_valid", 32'(pred_valid), 32'd1);
    chk("both_pred_taken", 32'(pred_taken), 32'd0);
    step();

    // Reset during the write strobe.
    res_valid = 1'b1;
    res_pc    = 2'b11;
    res_taken = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    step();
    chk("mid_strb_we", 32'(ram_we_n), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_strobes", 32'({ram_we_n, ram_cs_n, ram_data_oe}), 32'b110);
    chk("mid_rst_flags", 32'({ready, init_done}), 32'b00);
    rst = 1'b0;
    nw = wr_addr.size();
    step();
    chk("restart_addr", 32'(ram_addr), 32'd0);
    chk("restart_set", 32'({ram_cs_n, ram_we_n, ram_data_oe, ram_wdata}), 32'b01101);
    step();
    step();
    chk("restart_write", 32'(wr_addr.size()), 32'(nw + 1));
    chk("restart_wr_addr", 32'(wr_addr[$]), 32'd0);
    chk("strobe_exclusive", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
